// File: rtl/cpu_pkg.sv
// Shared types for the CPU front-end: address/instruction words, fetch phase and queue entry.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned BYTE_W  = 8;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [BYTE_W-1:0]  byte_t;

   typedef enum logic {
      LO = 1'b0,
      HI = 1'b1
   } fetch_phase_e;

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
   } fetch_entry_t;

   localparam addr_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Byte-RAM read port plus the execute-side instruction handshake and redirect.
interface fetch_unit_if;
   import cpu_pkg::*;

   addr_t  mem_addr;
   logic   mem_cs;
   logic   mem_we;
   byte_t  mem_rdata;
   logic   bus_gnt;
   logic   instr_valid;
   instr_t instr;
   addr_t  instr_pc;
   logic   instr_ready;
   logic   redirect_valid;
   addr_t  redirect_pc;

   modport master (
      output mem_addr, mem_cs, mem_we, instr_valid, instr, instr_pc,
      input  mem_rdata, bus_gnt, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_cs, mem_we, instr_valid, instr, instr_pc,
      output mem_rdata, bus_gnt, instr_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} with registered head; flush beats push and pop.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_valid,
   output fetch_entry_t           head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
   logic [CW-1:0] count_q, count_nxt, remain_c;
   logic          do_pop_c, do_push_c;
   fetch_entry_t  head_nxt;

   // Head is precomputed so the outputs come straight from flops.
   always_comb begin
      do_pop_c   = pop && (count_q != '0);
      do_push_c  = push && ((count_q != CW'(DEPTH)) || do_pop_c);
      remain_c   = count_q - CW'(do_pop_c);
      count_nxt  = remain_c + CW'(do_push_c);
      rd_ptr_nxt = rd_ptr_q + AW'(do_pop_c);
      head_nxt   = '0;
      if (remain_c != '0) begin
         head_nxt = mem_q[rd_ptr_nxt];
      end else if (do_push_c) begin
         head_nxt = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         head_valid <= 1'b0;
         head       <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_nxt;
         wr_ptr_q   <= wr_ptr_q + AW'(do_push_c);
         count_q    <= count_nxt;
         head_valid <= (count_nxt != '0);
         head       <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: two byte reads per 16-bit instruction, queued for execute, with redirect flush.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   fetch_phase_e  phase_q, phase_nxt, phase_cur_c;
   addr_t         fetch_pc_q, base_pc_c, issue_addr_c;
   logic          issue_c, issue_hi_c, issue_lo_c, room_c, pop_c, redirect;
   logic [CW-1:0] inflight_q, count;
   logic          mem_cs_q, iss_hi_q;
   addr_t         mem_addr_q;
   logic          ret_v_q, ret_hi_q, ret_drop_q;
   addr_t         ret_addr_q;
   byte_t         lo_hold_q;
   logic          cap_c, push_c;
   fetch_entry_t  push_data_c, head;
   logic          head_valid;

   assign redirect    = bus.redirect_valid;
   assign pop_c       = head_valid && bus.instr_ready;
   // A redirect restarts issue from redirect_pc in phase LO on the same edge.
   assign base_pc_c   = redirect ? bus.redirect_pc : fetch_pc_q;
   assign phase_cur_c = redirect ? LO : phase_q;
   assign room_c      = redirect ||
                        ((SW'(count) + SW'(inflight_q) - SW'(pop_c)) < SW'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) phase_q <= LO;
      else        phase_q <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase_cur_c;
      if (issue_c) begin
         phase_nxt = (phase_cur_c == LO) ? HI : LO;
      end
   end

   always_comb begin
      issue_c      = 1'b0;
      issue_hi_c   = 1'b0;
      issue_addr_c = '0;
      case (phase_cur_c)
         LO: begin
            if (bus.bus_gnt && room_c) begin
               issue_c      = 1'b1;
               issue_addr_c = base_pc_c;
            end
         end
         HI: begin
            if (bus.bus_gnt) begin
               issue_c      = 1'b1;
               issue_hi_c   = 1'b1;
               issue_addr_c = base_pc_c + ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign issue_lo_c = issue_c && !issue_hi_c;

   // Returned byte lines up with ret_*; the hi byte's pc minus one is the instruction pc.
   assign cap_c             = ret_v_q && !ret_drop_q && !redirect;
   assign push_c            = cap_c && ret_hi_q;
   assign push_data_c.pc    = ret_addr_q - ADDR_W'(1);
   assign push_data_c.instr = {bus.mem_rdata, lo_hold_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         mem_cs_q   <= 1'b0;
         mem_addr_q <= '0;
         iss_hi_q   <= 1'b0;
         ret_v_q    <= 1'b0;
         ret_hi_q   <= 1'b0;
         ret_drop_q <= 1'b0;
         ret_addr_q <= '0;
         lo_hold_q  <= '0;
         inflight_q <= '0;
      end else begin
         fetch_pc_q <= issue_hi_c ? base_pc_c + ADDR_W'(2) : base_pc_c;
         mem_cs_q   <= issue_c;
         mem_addr_q <= issue_addr_c;
         iss_hi_q   <= issue_hi_c;
         ret_v_q    <= mem_cs_q;
         ret_hi_q   <= iss_hi_q;
         ret_drop_q <= redirect;
         ret_addr_q <= mem_addr_q;
         if (cap_c && !ret_hi_q) begin
            lo_hold_q <= bus.mem_rdata;
         end
         if (redirect) inflight_q <= CW'(issue_lo_c);
         else          inflight_q <= inflight_q + CW'(issue_lo_c) - CW'(push_c);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (push_c),
      .push_data  (push_data_c),
      .pop        (pop_c),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_cs      = mem_cs_q;
   assign bus.mem_we      = 1'b0;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;

endmodule
